// File: rtl/fifo_reader_if.sv
// Pop-side handshake of a first-word fall-through byte FIFO.
// The reader (master) issues remove; the FIFO (slave) presents empty and its head entry.
interface fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             remove;
  logic             empty;
  logic [WIDTH-1:0] fifo_data;

  modport master (
    output remove,
    input  empty,
    input  fifo_data
  );

  modport slave (
    input  remove,
    output empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_reader.sv
// Consumer end of the byte FIFO: pops on a fixed interval or a manual step and
// keeps the last four popped bytes as a history word for the display.
module fifo_reader #(
  parameter int WIDTH    = 8,
  parameter int INTERVAL = 50000000,
  parameter int TW       = 26
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 step,
  input  logic                 clear,
  fifo_reader_if.master        fifo,
  output logic [4*WIDTH-1:0]   history,
  output logic [2:0]           count,
  output logic                 waiting
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_GAP
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(INTERVAL - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          expired;

  assign expired = (timer == TIMER_LAST);

  // The pop strobe is combinational so a flush (clear) or a drained FIFO in the
  // POP cycle suppresses it in that same cycle.
  assign fifo.remove = (state == S_POP) & ~fifo.empty & ~clear;
  assign waiting     = (state == S_WAIT) & expired & fifo.empty;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      history <= '0;
      count   <= 3'd0;
    end else if (clear) begin
      state   <= S_IDLE;
      timer   <= '0;
      history <= '0;
      count   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (step && !fifo.empty) begin
            state <= S_POP;
          end else if (enable) begin
            state <= S_WAIT;
          end
        end

        // Timer saturates at INTERVAL-1; a starved expiry stays here until data shows up.
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
            timer <= '0;
          end else if (step && !fifo.empty) begin
            state <= S_POP;
            timer <= '0;
          end else if (expired) begin
            if (!fifo.empty) begin
              state <= S_POP;
              timer <= '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_POP: begin
          if (fifo.remove) begin
            history <= {history[3*WIDTH-1:0], fifo.fifo_data};
            if (count != 3'd4) begin
              count <= count + 3'd1;
            end
          end
          state <= S_GAP;
        end

        S_GAP: begin
          timer <= '0;
          state <= enable ? S_WAIT : S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small FWFT FIFO model feeding the pop side.
module tb_fifo_reader;

  localparam int WIDTH    = 8;
  localparam int INTERVAL = 4;
  localparam int TW       = 3;

  logic               ck;
  logic               reset;
  logic               enable;
  logic               step;
  logic               clear;
  logic [4*WIDTH-1:0] history;
  logic [2:0]         count;
  logic               waiting;

  fifo_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_reader #(
    .WIDTH    (WIDTH),
    .INTERVAL (INTERVAL),
    .TW       (TW)
  ) dut (
    .ck      (ck),
    .reset   (reset),
    .enable  (enable),
    .step    (step),
    .clear   (clear),
    .fifo    (bus.master),
    .history (history),
    .count   (count),
    .waiting (waiting)
  );

  // FIFO model: pushes from the stimulus process, pops counted on remove.
  logic [WIDTH-1:0] mem [16];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int skip     = 0;
  int rd_idx;

  assign rd_idx        = pop_cnt + skip;
  assign bus.empty     = (rd_idx == push_cnt);
  assign bus.fifo_data = mem[rd_idx % 16];

  always @(posedge ck) begin
    if (bus.remove) pop_cnt <= pop_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic cl);
    enable = en;
    step   = st;
    clear  = cl;
  endtask

  task automatic pushByte(input logic [WIDTH-1:0] value);
    mem[push_cnt % 16] = value;
    push_cnt++;
  endtask

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // remove must never repeat on back-to-back cycles nor fire into an empty FIFO.
  logic prev_rm = 1'b0;
  always @(posedge ck) begin
    #1;
    if (reset) begin
      checkOutput("remove_rule", {31'd0, bus.remove & (prev_rm | bus.empty)}, 32'd0);
      prev_rm = bus.remove;
    end else begin
      prev_rm = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int target;
    logic exp_rm;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_history", history, 32'h0);
    checkOutput("rst_count", {29'd0, count}, 32'd0);
    checkOutput("rst_remove", {31'd0, bus.remove}, 32'd0);
    repeat (2) @(negedge ck);
    reset = 1'b1;

    // Idle with data available: nothing should be popped.
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    pushByte(8'h44);
    pushByte(8'h55);
    base = pop_cnt;
    repeat (20) @(negedge ck);
    checkOutput("idle_pops", pop_cnt - base, 32'd0);
    checkOutput("idle_remove", {31'd0, bus.remove}, 32'd0);

    // Periodic drain: removes at 5, 11, 17, 23, 29 cycles after enable.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge ck);
      exp_rm = (k >= 5) && (k <= 29) && (((k - 5) % 6) == 0);
      checkOutput($sformatf("periodic_rm_%0d", k), {31'd0, bus.remove}, {31'd0, exp_rm});
    end
    checkOutput("drain_history", history, 32'h22334455);
    checkOutput("drain_count", {29'd0, count}, 32'd4);
    checkOutput("drain_waiting", {31'd0, waiting}, 32'd1);

    // Starved then refilled: pop follows on the next cycle.
    pushByte(8'hA5);
    #1;
    checkOutput("refill_waiting", {31'd0, waiting}, 32'd0);
    @(negedge ck);
    checkOutput("refill_remove", {31'd0, bus.remove}, 32'd1);
    @(negedge ck);
    checkOutput("refill_history", history, 32'h334455A5);
    checkOutput("refill_count", {29'd0, count}, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Clear, then a manual step pop.
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_history", history, 32'h0);
    checkOutput("clear_count", {29'd0, count}, 32'd0);
    pushByte(8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("step_remove", {31'd0, bus.remove}, 32'd1);
    @(negedge ck);
    checkOutput("step_remove_once", {31'd0, bus.remove}, 32'd0);
    checkOutput("step_history", history, 32'h0000003C);
    checkOutput("step_count", {29'd0, count}, 32'd1);
    @(negedge ck);
    base = pop_cnt;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("step_empty_rm", {31'd0, bus.remove}, 32'd0);
    @(negedge ck);
    checkOutput("step_empty_pops", pop_cnt - base, 32'd0);
    checkOutput("step_empty_count", {29'd0, count}, 32'd1);

    // Clear arriving in the POP cycle wins over the capture.
    pushByte(8'h77);
    base = pop_cnt;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("race_remove", {31'd0, bus.remove}, 32'd0);
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("race_history", history, 32'h0);
    checkOutput("race_count", {29'd0, count}, 32'd0);
    repeat (3) @(negedge ck);
    checkOutput("race_pops", pop_cnt - base, 32'd0);
    checkOutput("race_empty", {31'd0, bus.empty}, 32'd0);
    skip = push_cnt - pop_cnt;

    // Build count=3, sit starved in WAIT, then pulse the async reset.
    pushByte(8'h01);
    pushByte(8'h02);
    pushByte(8'h03);
    target = pop_cnt + 3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && pop_cnt != target; i++) @(negedge ck);
    checkOutput("fill3_reached", pop_cnt, target);
    repeat (6) @(negedge ck);
    checkOutput("fill3_count", {29'd0, count}, 32'd3);
    checkOutput("fill3_history", history, 32'h00010203);
    checkOutput("fill3_waiting", {31'd0, waiting}, 32'd1);
    @(posedge ck);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_history", history, 32'h0);
    checkOutput("async_count", {29'd0, count}, 32'd0);
    checkOutput("async_remove", {31'd0, bus.remove}, 32'd0);
    checkOutput("async_waiting", {31'd0, waiting}, 32'd0);
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge ck);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Consumer end of the byte FIFO. Pops entries at a fixed interval, or on a manual step pulse, using the FIFO's remove/empty/data interface.
- Keeps the last four popped bytes as a history word. The eight-digit display front end shows this history.
- The FIFO is first-word fall-through: fifo_data is valid whenever empty=0, and a remove pulse pops on the clock edge.

Parameters:
- WIDTH, 8, data width of one FIFO entry.
- INTERVAL, 50000000, clock cycles between automatic pops (minimum 2).
- TW, 26, timer width; must satisfy 2^TW >= INTERVAL.

Ports:
- ck  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 = automatic periodic popping.
- step  input  1  single-cycle pulse (debounced button); requests one immediate pop.
- clear  input  1  synchronous clear of history, count and timer (driven together with FIFO flush).
- empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO head entry.
- remove  output  1  single-cycle pop strobe to the FIFO.
- history  output  4*WIDTH  popped bytes; [WIDTH-1:0] is the newest, [4*WIDTH-1:3*WIDTH] the oldest.
- count  output  3  number of valid history entries, 0..4, saturating.
- waiting  output  1  1 when the timer has expired but the FIFO is empty.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timer=0, history=0, count=0. remove=0 and waiting=0 immediately.
- States and transitions:
  - IDLE: timer held at 0.
    - step=1 and empty=0 -> POP.
    - else enable=1 -> WAIT.
  - WAIT: timer increments each cycle up to INTERVAL-1, then holds there.
    - enable=0 -> IDLE; timer cleared.
    - step=1 and empty=0 -> POP (early pop).
    - timer==INTERVAL-1 and empty=0 -> POP.
    - timer==INTERVAL-1 and empty=1 -> stay in WAIT; waiting=1. Pop on the first cycle empty=0.
  - POP: one cycle.
    - remove = (state==POP) & ~empty & ~clear (combinational).
    - On the edge ending POP, if remove=1: history <= {history[3*WIDTH-1:0], fifo_data}; count <= min(count+1, 4).
    - Always -> GAP.
  - GAP: one cycle so the FIFO empty flag can settle; timer cleared.
    - -> WAIT if enable=1, else IDLE.
- step pulses arriving in POP or GAP are ignored, not queued.
- clear=1, any state: history=0, count=0, timer=0, next state IDLE. clear has priority over capture and transitions.
- If empty=1 in POP (e.g. flush race): no remove, no capture, still -> GAP.
- Throughput:
  - Automatic mode: one pop every INTERVAL+2 cycles (WAIT INTERVAL cycles, POP, GAP).
  - Manual mode: at most one pop per 3 cycles.
- remove is never high on two consecutive cycles, and never high while empty=1.
- The history shift discards the oldest byte when count=4. count stays at 4.

Test Plan:
- Reset/idle, INTERVAL=4: after reset, history=0, count=0, remove=0. Hold enable=0, empty=0 for 20 cycles -> no remove.
- Periodic drain, INTERVAL=4: FIFO preloaded 0x11,0x22,0x33,0x44,0x55; enable=1.
  - remove pulses every 6 cycles.
  - After 5 pops: history=0x22334455, count=4. Then empty=1 -> no more remove, waiting=1.
- Starved then refill: enable=1, FIFO empty past timer expiry -> waiting=1. Insert 0xA5 -> remove on the next cycle in WAIT; history[7:0]=0xA5, waiting=0.
- Manual step: enable=0, FIFO holds 0x3C; step pulse -> remove exactly one cycle later, history[7:0]=0x3C, count=1. Step with empty=1 -> no remove.
- Clear/flush race: clear=1 in the same cycle as POP with data 0x77 -> remove=0, history=0, count=0, state IDLE.
- Async reset mid-WAIT with count=3: drop reset for half a cycle -> outputs are 0 immediately, before the next ck edge.
